// File: rtl/uart_pkg.sv
// Shared UART constants, divisor helper and receiver state encoding.
// Used by uart_rx and by the transmitter, which reuses DIV for its own baud divider.
// No logic here; pure compile-time definitions.
package uart_pkg;

    localparam int CLK_HZ = 100_000_000;
    localparam int BAUD   = 9600;
    localparam int OS     = 16;

    // Tick divisor with integer truncation; the rounding error stays
    // well under 0.01% at the default clock/baud.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        return clk_hz / (baud * os);
    endfunction

    localparam int DIV = calc_div(CLK_HZ, BAUD, OS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
// Latency: tick fires DIV cycles after a synchronous clear.
// Backpressure: none; the tick is a strobe and is never held.
//
// Ports:
//   i_clk   clock, rising edge
//   i_rst   asynchronous active-high reset
//   i_clr   synchronous clear, restarts the count at 0 (no tick that cycle)
//   o_tick  one-cycle pulse when the count reaches DIV-1
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // A clear takes priority so the restarted interval is a full DIV cycles.
    assign o_tick = w_last && !i_clr;

endmodule

// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver with sticky ready/overrun and ack handshake.
// Latency: byte presented one cycle after the mid-stop sample (152*DIV cycles after start detection).
// Backpressure: none on the line; an unacknowledged byte is overwritten and flagged via rx_overrun.
//
// Ports:
//   CLK100MHZ     system clock, rising edge
//   RST           asynchronous active-high reset
//   RxD           serial input, idle high, asynchronous to the clock
//   rx_ack        one-cycle pulse: consumer has taken rx_data
//   rx_data       last good byte, held until the next good frame
//   rx_ready      sticky: a good byte is waiting, cleared by rx_ack
//   rx_valid      one-cycle pulse per good frame
//   rx_frame_err  one-cycle pulse when the stop bit samples low
//   rx_overrun    sticky: good frame arrived while rx_ready=1, cleared by rx_ack
//   rx_busy       high whenever the receiver is not idle
module uart_rx #(
    parameter int CLK_HZ = uart_pkg::CLK_HZ,
    parameter int BAUD   = uart_pkg::BAUD,
    parameter int OS     = uart_pkg::OS     // only 16 is supported (os_cnt is 4 bits)
) (
    input  logic       CLK100MHZ,
    input  logic       RST,
    input  logic       RxD,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    import uart_pkg::*;

    localparam int RX_DIV = calc_div(CLK_HZ, BAUD, OS);

    // ------------------------------------------------------------------
    // Two-flop synchronizer; resets to the idle (high) line level so a
    // reset never looks like a start bit.
    // ------------------------------------------------------------------
    logic [1:0] r_sync;
    logic       w_rxs;

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], RxD};
        end
    end

    assign w_rxs = r_sync[1];

    // ------------------------------------------------------------------
    // Oversample tick. Restarting the divider on start detection aligns
    // the sample points to the falling edge of the start bit.
    // ------------------------------------------------------------------
    rx_state_t r_state;
    logic      w_start_det;
    logic      w_tick;

    assign w_start_det = (r_state == S_IDLE) && !w_rxs;

    uart_baud_tick #(
        .DIV (RX_DIV)
    ) u_baud_tick (
        .i_clk  (CLK100MHZ),
        .i_rst  (RST),
        .i_clr  (w_start_det),
        .o_tick (w_tick)
    );

    // ------------------------------------------------------------------
    // Receive FSM with registered outputs.
    // ------------------------------------------------------------------
    logic [3:0] r_os_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_ready;
    logic       r_valid;
    logic       r_frame_err;
    logic       r_overrun;
    logic       r_busy;

    logic       w_stop_smp;
    logic       w_good;

    // Mid-stop-bit sample point; a high line there completes a good frame.
    assign w_stop_smp = (r_state == S_STOP) && w_tick && (r_os_cnt == 4'd15);
    assign w_good     = w_stop_smp && w_rxs;

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_os_cnt    <= 4'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_ready     <= 1'b0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state   <= S_START;
                        r_os_cnt  <= 4'd0;
                        r_bit_cnt <= 3'd0;
                        r_busy    <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_tick) begin
                        if (r_os_cnt == 4'd7) begin
                            r_os_cnt <= 4'd0;
                            if (!w_rxs) begin
                                r_state <= S_DATA;
                            end else begin
                                // Line went back high by mid start bit: glitch.
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 4'd1;
                        end
                    end
                end

                S_DATA: begin
                    if (w_tick) begin
                        // 4-bit counter wraps 15->0, giving one sample per bit.
                        r_os_cnt <= r_os_cnt + 4'd1;
                        if (r_os_cnt == 4'd15) begin
                            // LSB arrives first, so shift in from the top.
                            r_shift <= {w_rxs, r_shift[7:1]};
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt <= 3'd0;
                                r_state   <= S_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                end

                S_STOP: begin
                    if (w_tick) begin
                        r_os_cnt <= r_os_cnt + 4'd1;
                        if (r_os_cnt == 4'd15) begin
                            if (w_rxs) begin
                                // Back to IDLE now so a start bit right after
                                // the stop bit loses no cycles.
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= S_BREAK;
                            end
                        end
                    end
                end

                S_BREAK: begin
                    // Hold off retriggering while the line sits low.
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Consumer handshake. A good frame in the same cycle as an ack
            // wins: the new byte stays ready and no overrun is flagged.
            if (w_good) begin
                r_data    <= r_shift;
                r_valid   <= 1'b1;
                r_ready   <= 1'b1;
                r_overrun <= r_ready && !rx_ack;
            end else if (rx_ack) begin
                r_ready   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx_data      = r_data;
    assign rx_ready     = r_ready;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_frame_err;
    assign rx_overrun   = r_overrun;
    assign rx_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: scoreboard of expected frame events plus a byte-level
// model of the ready/overrun/data handshake state.
// Runs the receiver with a reduced clock ratio so each bit is 96 cycles.
module tb_uart_rx;

    localparam int TB_CLK_HZ = 1_000_000;
    localparam int TB_BAUD   = 9600;
    localparam int TB_OS     = 16;
    localparam int TDIV      = TB_CLK_HZ / (TB_BAUD * TB_OS); // 6
    localparam int BITC      = TDIV * TB_OS;                  // cycles per bit

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       ack;
    logic [7:0] rx_data;
    logic       rx_ready, rx_valid, rx_frame_err, rx_overrun, rx_busy;

    uart_rx #(
        .CLK_HZ (TB_CLK_HZ),
        .BAUD   (TB_BAUD),
        .OS     (TB_OS)
    ) dut (
        .CLK100MHZ    (clk),
        .RST          (rst),
        .RxD          (rxd),
        .rx_ack       (ack),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int last_valid_cyc = 0;
    int frame_start_cyc = 0;

    // Byte-level model of what the consumer should see.
    logic [7:0] m_data    = 8'h00;
    bit         m_ready   = 1'b0;
    bit         m_overrun = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every output event must match the head of the expected queue.
    initial forever begin
        @(negedge clk);
        if (!rst && (rx_valid || rx_frame_err)) begin
            if (rx_valid) begin
                n_valid++;
                last_valid_cyc = cyc;
            end
            if (rx_frame_err) n_err++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: got valid=%0b err=%0b data=%0h, required none",
                         rx_valid, rx_frame_err, rx_data);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("event_kind_err", 32'(rx_frame_err), 32'(e.is_err));
                check("event_kind_valid", 32'(rx_valid), 32'(!e.is_err));
                if (!e.is_err) check("sb_rx_data", 32'(rx_data), 32'(e.data));
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        wait_cycles(BITC);
    endtask

    // mode 0: good frame expected, 1: stop bit low (frame error), 2: no event expected.
    // Called aligned to a falling clock edge; leaves rxd at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input int mode);
        ev_t e;
        if (mode == 0) begin
            e.is_err = 1'b0; e.data = d; exp_q.push_back(e);
        end else if (mode == 1) begin
            e.is_err = 1'b1; e.data = 8'h00; exp_q.push_back(e);
        end
        frame_start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(mode != 1);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int start;
        int k;
        start = n_valid;
        k = 0;
        while (n_valid == start && k < 12 * BITC) begin
            @(negedge clk);
            k++;
        end
        if (n_valid == start) begin
            tests++;
            fails++;
            $display("FAIL %s: got no rx_valid, required one within %0d cycles", name, 12 * BITC);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_ready"}, 32'(rx_ready), 32'(m_ready));
        check({tag, "_overrun"}, 32'(rx_overrun), 32'(m_overrun));
        check({tag, "_data"}, 32'(rx_data), 32'(m_data));
    endtask

    // Model update for a good frame with no ack in the same cycle.
    task automatic model_good(input logic [7:0] d);
        m_overrun = m_overrun | m_ready;
        m_ready   = 1'b1;
        m_data    = d;
    endtask

    task automatic model_ack();
        m_ready   = 1'b0;
        m_overrun = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0, e0, g0, lat, k;
        logic [7:0] b;
        bit ok;

        rst = 1'b1;
        rxd = 1'b1;
        ack = 1'b0;
        wait_cycles(3);

        check("reset_data", 32'(rx_data), 32'h00);
        check("reset_ready", 32'(rx_ready), 32'd0);
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_frame_err", 32'(rx_frame_err), 32'd0);
        check("reset_overrun", 32'(rx_overrun), 32'd0);
        check("reset_busy", 32'(rx_busy), 32'd0);

        rst = 1'b0;
        wait_cycles(5);

        // Good frame 0x41 with latency window 9.5 bit times +/- one tick.
        v0 = n_valid;
        send_frame(8'h41, 0);
        model_good(8'h41);
        check("t1_valid_count", 32'(n_valid - v0), 32'd1);
        check_model("t1");
        lat = last_valid_cyc - frame_start_cyc;
        check("t1_latency_in_window",
              32'(lat >= (152 * TDIV - TDIV) && lat <= (152 * TDIV + TDIV)), 32'd1);
        pulse_ack();
        model_ack();
        check_model("t1_ack");

        // Ack with nothing waiting has no effect.
        pulse_ack();
        check_model("ack_idle");

        // Back-to-back 0x00 then 0xFF, acked after each.
        v0 = n_valid;
        fork
            begin
                send_frame(8'h00, 0);
                send_frame(8'hFF, 0);
            end
            begin
                wait_valid("b2b_first");
                pulse_ack();
                wait_valid("b2b_second");
                pulse_ack();
            end
        join
        m_data = 8'hFF;
        model_ack();
        check("b2b_valid_count", 32'(n_valid - v0), 32'd2);
        check_model("b2b");
        wait_cycles(2 * BITC);

        // False start: 3-cycle glitch, busy for half a bit then idle.
        v0 = n_valid;
        g0 = cyc;
        rxd = 1'b0;
        wait_cycles(3);
        rxd = 1'b1;
        k = 0;
        while (!rx_busy && k < 10) begin @(negedge clk); k++; end
        check("glitch_busy_rise", 32'(rx_busy), 32'd1);
        k = 0;
        while (rx_busy && k < 20 * TDIV) begin @(negedge clk); k++; end
        check("glitch_busy_fall", 32'(rx_busy), 32'd0);
        lat = cyc - g0;
        check("glitch_busy_time",
              32'(lat >= 8 * TDIV && lat <= 8 * TDIV + 5), 32'd1);
        check("glitch_no_valid", 32'(n_valid - v0), 32'd0);
        check_model("glitch");
        wait_cycles(BITC);

        // Framing error with a byte already waiting, then a break.
        send_frame(8'h5A, 0);
        model_good(8'h5A);
        drive_bit(1'b1);
        v0 = n_valid;
        e0 = n_err;
        send_frame(8'h55, 1);
        wait_cycles(5 * BITC);
        check("break_busy", 32'(rx_busy), 32'd1);
        wait_cycles(15 * BITC);
        check("ferr_count", 32'(n_err - e0), 32'd1);
        check("break_no_valid", 32'(n_valid - v0), 32'd0);
        check_model("ferr");
        rxd = 1'b1;
        wait_cycles(2 * BITC);
        check("break_exit_idle", 32'(rx_busy), 32'd0);
        send_frame(8'h41, 0);
        model_good(8'h41);
        check_model("after_break");
        pulse_ack();
        model_ack();
        check_model("after_break_ack");
        drive_bit(1'b1);

        // Overrun: two frames without ack.
        send_frame(8'h12, 0);
        model_good(8'h12);
        send_frame(8'h34, 0);
        model_good(8'h34);
        check_model("overrun");
        pulse_ack();
        model_ack();
        check_model("overrun_ack");
        drive_bit(1'b1);

        // Reset during data bit 3. 0xF5 has bit3=0 and bits 4..7=1, so the
        // low level left after reset reads as a false start at mid-sample.
        send_frame(8'h77, 0);
        model_good(8'h77);
        drive_bit(1'b1);
        v0 = n_valid;
        e0 = n_err;
        fork
            send_frame(8'hF5, 2);
            begin
                wait_cycles(4 * BITC + 40);
                rst = 1'b1;
                #1;
                check("midrst_data", 32'(rx_data), 32'h00);
                check("midrst_ready", 32'(rx_ready), 32'd0);
                check("midrst_valid", 32'(rx_valid), 32'd0);
                check("midrst_frame_err", 32'(rx_frame_err), 32'd0);
                check("midrst_overrun", 32'(rx_overrun), 32'd0);
                check("midrst_busy", 32'(rx_busy), 32'd0);
                wait_cycles(10);
                rst = 1'b0;
            end
        join
        m_ready = 1'b0;
        m_overrun = 1'b0;
        m_data = 8'h00;
        wait_cycles(2 * BITC);
        check("midrst_no_valid", 32'(n_valid - v0), 32'd0);
        check_model("midrst");
        send_frame(8'h41, 0);
        model_good(8'h41);
        check_model("post_rst");
        pulse_ack();
        model_ack();

        // Randomized frames, stop bits, gaps and acks.
        for (int i = 0; i < 8; i++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_frame(b, ok ? 0 : 1);
            if (ok) model_good(b);
            check_model("rand");
            rxd = 1'b1;
            wait_cycles($urandom_range(ok ? 0 : 1, 2) * BITC);
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                model_ack();
                check_model("rand_ack");
            end
        end

        wait_cycles(2 * BITC);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
